// File: rtl/zl_prbs_checker.sv
// zl_prbs_checker -- self-synchronising PRBS checker.
//
// A reference LFSR is loaded from the received stream while hunting. It then
// free-runs to predict every incoming bit, and it reports the per-bit
// mismatches. Lock is declared after LOCK_count clean beats. Lock is dropped
// after UNLOCK_count consecutive errored beats.
//
// Optional feature macro: ZL_PRBS_CHK_ERR_CNT_EN
//   defined   -> err_count accumulates bit errors seen while locked (saturating)
//   undefined -> no counter logic, err_count tied to 0
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   clear      in   synchronous restart (wins over in_valid)
//   in_valid   in   data_in holds a beat this cycle
//   data_in    in   [PRBS_width] received bits, MSb earliest
//   locked     out  high while in LOCKED
//   err_valid  out  err_vec valid (registered)
//   err_vec    out  [PRBS_width] per-bit mismatch, 1 = error
//   err_count  out  [32] accumulated bit errors while locked
//   lfsr_state out  [LFSR_width] reference LFSR state
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_HUNT   | shifting received bits into the LFSR until it is full
// S_VERIFY | free-running LFSR, counting consecutive clean beats
// S_LOCKED | free-running LFSR, counting consecutive errored beats

module zl_prbs_checker #(
  parameter logic [31:0] LFSR_poly    = 32'h0,
  parameter int          LFSR_width   = 0,
  parameter int          PRBS_width   = 0,
  parameter int          LOCK_count   = 4,
  parameter int          UNLOCK_count = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [PRBS_width-1:0] data_in,
  output logic                  locked,
  output logic                  err_valid,
  output logic [PRBS_width-1:0] err_vec,
  output logic [31:0]           err_count,
  output logic [LFSR_width-1:0] lfsr_state
);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

  state_t                st_q, st_d;
  logic [LFSR_width-1:0] lfsr_q, lfsr_d, hunt_nxt, gen_nxt;
  logic [PRBS_width-1:0] pred, err_raw, err_vec_q, err_vec_d;
  logic [7:0]            fill_q, fill_d, fill_sum;
  logic [7:0]            good_q, good_d, bad_q, bad_d;
  logic                  err_valid_q, err_valid_d;
  logic                  locked_q;

  // Both candidate next states are built bit-serially, MSb of data_in first.
  // The hunt path shifts in the received bits. The generator path shifts in
  // the predicted feedback bits.
  always_comb begin
    hunt_nxt = lfsr_q;
    gen_nxt  = lfsr_q;
    pred     = '0;
    for (int i = PRBS_width - 1; i >= 0; i--) begin
      hunt_nxt = {hunt_nxt[LFSR_width-2:0], data_in[i]};
      pred[i]  = ^(gen_nxt & LFSR_poly[LFSR_width:1]);
      gen_nxt  = {gen_nxt[LFSR_width-2:0], pred[i]};
    end
    err_raw = pred ^ data_in;
  end

  always_comb begin
    st_d        = st_q;
    lfsr_d      = lfsr_q;
    fill_d      = fill_q;
    good_d      = good_q;
    bad_d       = bad_q;
    err_valid_d = 1'b0;
    err_vec_d   = '0;
    fill_sum    = fill_q + 8'(PRBS_width);
    if (clear) begin
      st_d   = S_HUNT;
      lfsr_d = '0;
      fill_d = '0;
      good_d = '0;
      bad_d  = '0;
    end else if (in_valid) begin
      case (st_q)
        S_HUNT: begin
          lfsr_d = hunt_nxt;
          if (fill_sum >= 8'(LFSR_width)) begin
            st_d   = S_VERIFY;
            fill_d = '0;
          end else begin
            fill_d = fill_sum;
          end
        end
        S_VERIFY: begin
          lfsr_d      = gen_nxt;
          err_valid_d = 1'b1;
          err_vec_d   = err_raw;
          if (err_raw != '0) begin
            st_d   = S_HUNT;
            fill_d = '0;
            good_d = '0;
            bad_d  = '0;
          end else if (good_q + 8'd1 == 8'(LOCK_count)) begin
            st_d   = S_LOCKED;
            good_d = '0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
        S_LOCKED: begin
          lfsr_d      = gen_nxt;
          err_valid_d = 1'b1;
          err_vec_d   = err_raw;
          if (err_raw == '0) begin
            bad_d = '0;
          end else if (bad_q + 8'd1 == 8'(UNLOCK_count)) begin
            st_d   = S_HUNT;
            fill_d = '0;
            bad_d  = '0;
            good_d = '0;
          end else begin
            bad_d = bad_q + 8'd1;
          end
        end
        default: st_d = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= S_HUNT;
      lfsr_q      <= '0;
      fill_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_valid_q <= 1'b0;
      err_vec_q   <= '0;
      locked_q    <= 1'b0;
    end else begin
      st_q        <= st_d;
      lfsr_q      <= lfsr_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_valid_q <= err_valid_d;
      err_vec_q   <= err_vec_d;
      locked_q    <= (st_d == S_LOCKED);
    end
  end

`ifdef ZL_PRBS_CHK_ERR_CNT_EN
  logic [31:0] err_count_q, err_count_d, pop;
  logic [32:0] cnt_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < PRBS_width; i++) pop = pop + 32'(err_raw[i]);
    cnt_sum     = {1'b0, err_count_q} + {1'b0, pop};
    err_count_d = err_count_q;
    if (clear) begin
      err_count_d = '0;
    end else if (in_valid && st_q == S_LOCKED) begin
      // Saturate rather than wrap, so a long errored run never reads as low.
      err_count_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 32'h0;
`endif

  assign locked     = locked_q;
  assign err_valid  = err_valid_q;
  assign err_vec    = err_vec_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_zl_prbs_checker.sv
// Testbench for zl_prbs_checker, configured as a PRBS7 checker (x^7+x^6+1),
// 4 bits per beat. A continuous generator with seed 7'h7F feeds the checker,
// and each table row may XOR an error mask into its beat.
module tb_zl_prbs_checker;

`ifdef ZL_PRBS_CHK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic       locked, err_valid;
  logic [3:0] err_vec;
  logic [31:0] err_count;
  logic [6:0] lfsr_state;

  zl_prbs_checker #(
    .LFSR_poly(32'hC1), .LFSR_width(7), .PRBS_width(4),
    .LOCK_count(4), .UNLOCK_count(4)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .data_in(data_in), .locked(locked), .err_valid(err_valid),
    .err_vec(err_vec), .err_count(err_count), .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  // lfsr mode: 0 = not checked, 1 = equals generator state, 2 = zero
  typedef struct {
    bit         valid;
    bit         clr;
    logic [3:0] mask;
    bit         ev;
    logic [3:0] vec;
    bit         lk;
    int unsigned cnt;
    int         lmode;
  } vec_t;

  typedef struct {
    bit         ev;
    logic [3:0] vec;
    bit         lk;
    logic [31:0] cnt;
    int         lmode;
    logic [6:0] lfsr;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic [6:0] gen_state = 7'h7F;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent generator: x^7+x^6+1, feedback taken from bits 6 and 5.
  task automatic next_beat(output logic [3:0] d);
    logic fb;
    d = 4'h0;
    for (int i = 3; i >= 0; i--) begin
      fb = gen_state[6] ^ gen_state[5];
      gen_state = {gen_state[5:0], fb};
      d[i] = fb;
    end
  endtask

  function automatic vec_t mk(bit v, bit c, logic [3:0] m, bit ev, logic [3:0] vec,
                              bit lk, int unsigned cnt, int lmode);
    vec_t r;
    r.valid = v; r.clr = c; r.mask = m; r.ev = ev; r.vec = vec;
    r.lk = lk; r.cnt = cnt; r.lmode = lmode;
    return r;
  endfunction

  // Called at posedge+1; drives one cycle and compares just after the next edge.
  task automatic apply(input vec_t v, input int idx);
    logic [3:0] d;
    exp_t e, g;
    d = 4'h0;
    if (v.valid) begin
      next_beat(d);
      d = d ^ v.mask;
    end
    in_valid = v.valid;
    clear    = v.clr;
    data_in  = d;
    e.ev = v.ev; e.vec = v.vec; e.lk = v.lk;
    e.cnt = CNT_EN ? v.cnt : 32'd0;
    e.lmode = v.lmode; e.lfsr = gen_state;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    if (sb.size() == 0) begin
      check($sformatf("scoreboard_empty[%0d]", idx), 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      check($sformatf("err_valid[%0d]", idx), 32'(err_valid), 32'(g.ev));
      check($sformatf("err_vec[%0d]", idx), 32'(err_vec), 32'(g.vec));
      check($sformatf("locked[%0d]", idx), 32'(locked), 32'(g.lk));
      check($sformatf("err_count[%0d]", idx), err_count, g.cnt);
      if (g.lmode == 1) check($sformatf("lfsr_gen[%0d]", idx), 32'(lfsr_state), 32'(g.lfsr));
      if (g.lmode == 2) check($sformatf("lfsr_zero[%0d]", idx), 32'(lfsr_state), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
    check({tag, "_err_vec"}, 32'(err_vec), 32'd0);
    check({tag, "_err_count"}, err_count, 32'd0);
    check({tag, "_lfsr"}, 32'(lfsr_state), 32'd0);
  endtask

  int n_a;

  initial begin
    // Phase A: acquire, single-bit error, unlock by inversion, relock,
    // clear with simultaneous beat, error on the 2nd VERIFY beat, relock.
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0, 0,0));  // 0 hunt
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0, 0,1));  // 1 hunt, full
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));  // 2 verify
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));  // 3
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));  // 4
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,1, 0,1));  // 5 locks
    tbl.push_back(mk(0,0,4'h0, 0,4'h0,1, 0,1));  // 6 idle holds
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,1, 0,1));  // 7 locked clean
    tbl.push_back(mk(1,0,4'h8, 1,4'h8,1, 1,1));  // 8 flip data_in[3]
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,1, 1,1));  // 9
    tbl.push_back(mk(1,0,4'hF, 1,4'hF,1, 5,1));  // 10 inverted
    tbl.push_back(mk(1,0,4'hF, 1,4'hF,1, 9,1));  // 11
    tbl.push_back(mk(1,0,4'hF, 1,4'hF,1,13,1));  // 12
    tbl.push_back(mk(1,0,4'hF, 1,4'hF,0,17,1));  // 13 unlock
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0,17,0));  // 14 hunt
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0,17,1));  // 15 hunt
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0,17,1));  // 16 verify
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0,17,1));  // 17
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0,17,1));  // 18
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,1,17,1));  // 19 relocked
    tbl.push_back(mk(1,1,4'h0, 0,4'h0,0, 0,2));  // 20 clear + beat
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0, 0,0));  // 21 hunt
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0, 0,1));  // 22 hunt
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));  // 23 verify 1
    tbl.push_back(mk(1,0,4'h4, 1,4'h4,0, 0,1));  // 24 verify 2 errored
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0, 0,0));  // 25 hunt
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0, 0,1));  // 26 hunt
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));  // 27
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));  // 28
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));  // 29
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,1, 0,1));  // 30 locked
    tbl.push_back(mk(1,0,4'h2, 1,4'h2,1, 1,1));  // 31 flip data_in[1]
    n_a = tbl.size();
    // Phase B: after a mid-stream reset, relock in 6 clean beats.
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0, 0,0));  // hunt
    tbl.push_back(mk(1,0,4'h0, 0,4'h0,0, 0,1));  // hunt
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,0, 0,1));
    tbl.push_back(mk(1,0,4'h0, 1,4'h0,1, 0,1));  // locked
    tbl.push_back(mk(1,0,4'h1, 1,4'h1,1, 1,1));  // flip data_in[0]

    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < n_a; i++) apply(tbl[i], i);

    // Asynchronous reset in the middle of a beat: outputs drop immediately
    // and that beat is discarded.
    begin
      logic [3:0] d;
      next_beat(d);
      in_valid = 1'b1;
      data_in  = d;
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst = 1'b0;
      check_reset_outputs("midrst_held");
    end

    for (int i = n_a; i < tbl.size(); i++) apply(tbl[i], i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zl_prbs_checker.md
ZL_PRBS_CHECKER -- requirements
Module: zl_prbs_checker

Interface
REQ-001 SHALL have parameter LFSR_poly, default 0, generator polynomial; bits [LFSR_width:1] are the feedback taps on state bits [LFSR_width-1:0].
REQ-002 SHALL have parameter LFSR_width, default 0, LFSR register width; legal range 2..31.
REQ-003 SHALL have parameter PRBS_width, default 0, received bits per beat; legal range 1..LFSR_width.
REQ-004 SHALL have parameter LOCK_count, default 4, consecutive error-free beats in VERIFY required to reach LOCKED; legal range 1..255.
REQ-005 SHALL have parameter UNLOCK_count, default 4, consecutive errored beats in LOCKED that force HUNT; legal range 1..255.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port clear, input, 1, synchronous restart of the checker.
REQ-009 SHALL have port in_valid, input, 1, data_in carries a beat this cycle.
REQ-010 SHALL have port data_in, input, PRBS_width, received PRBS bits; MSb is earliest in time.
REQ-011 SHALL have port locked, output, 1, high while FSM is in LOCKED.
REQ-012 SHALL have port err_valid, output, 1, err_vec is valid this cycle.
REQ-013 SHALL have port err_vec, output, PRBS_width, per-bit mismatch, 1 = bit error, same bit order as data_in.
REQ-014 SHALL have port err_count, output, 32, accumulated bit errors while locked.
REQ-015 SHALL have port lfsr_state, output, LFSR_width, current reference LFSR state.

Function
REQ-016 SHALL implement FSM states HUNT, VERIFY, LOCKED; all state changes occur only on cycles with in_valid=1, except clear and reset.
REQ-017 Serial step SHALL be: state <= {state[LFSR_width-2:0], ^(state & LFSR_poly[LFSR_width:1])}; the new state[0] is the predicted bit; one beat applies PRBS_width serial steps, MSb of data_in first.
REQ-018 HUNT: each beat SHALL shift received bits into state serially (state <= {state[LFSR_width-2:0], rx_bit}, MSb first) and add PRBS_width to a fill counter; once fill >= LFSR_width after a beat, go VERIFY and zero fill.
REQ-019 VERIFY and LOCKED: state SHALL advance by REQ-017 only, independent of data_in; err_vec = predicted XOR data_in.
REQ-020 VERIFY: beat with err_vec==0 SHALL increment the good-beat counter, reaching LOCK_count -> LOCKED; any nonzero err_vec SHALL return to HUNT with fill and counters zeroed.
REQ-021 LOCKED: nonzero err_vec SHALL increment the bad-beat counter, zero err_vec SHALL zero it; reaching UNLOCK_count -> HUNT with fill zeroed.
REQ-022 err_valid and err_vec SHALL be registered, asserted one cycle after an in_valid beat in VERIFY or LOCKED; err_valid=0 and err_vec=0 otherwise.
REQ-023 err_count SHALL add popcount(err_vec) of each LOCKED beat, saturating at 32'hFFFFFFFF; it is not cleared on loss of lock.
REQ-024 locked SHALL be registered and change in the cycle after the transitioning beat.
REQ-025 clear=1 SHALL on the next edge force HUNT, zero fill, beat counters, err_count, err_vec, err_valid and state; clear wins over a simultaneous in_valid beat.
REQ-026 in_valid=0 SHALL hold all state, counters and lfsr_state, and deassert err_valid.

Reset
REQ-027 rst=1 SHALL asynchronously force HUNT, state=0, fill=0, all counters 0, locked=0, err_valid=0, err_vec=0, err_count=0.
REQ-028 Reset mid-beat SHALL discard that beat; first beat after release is treated as HUNT fill.

Configuration
REQ-029 Macro ZL_PRBS_CHK_ERR_CNT_EN defined: err_count per REQ-023; undefined: counter logic absent, err_count tied to 0, all other behaviour identical.

Verification
REQ-030 PRBS7 (LFSR_poly=8'hC1, LFSR_width=7, PRBS_width=4, LOCK_count=4), generator seed 7'h7F fed continuously -> HUNT 2 beats, VERIFY 4 beats, locked=1 one cycle after 6th beat, err_vec always 0.
REQ-031 Locked stream, flip data_in[3] on one beat -> err_vec=4'b1000 with err_valid next cycle, err_count=1, locked stays 1.
REQ-032 Locked, UNLOCK_count=4, invert every bit for 4 beats -> locked=0 after 4th beat, err_count=16, HUNT then relock within 6 clean beats.
REQ-033 Error injected on 2nd VERIFY beat -> return to HUNT, locked never asserts, err_count stays 0.
REQ-034 clear and in_valid high together while locked, then rst pulse mid-stream -> next cycle locked=0, err_count=0, state=0; relock after 6 clean beats.
REQ-035 Build without ZL_PRBS_CHK_ERR_CNT_EN, repeat REQ-031 -> err_count=0, err_vec and locked identical.
